alu_seq: RTL

//  Parametrised, registered successor to the processor's 4-bit combinational ALU.

---
 rtl/alu_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
// Single-cycle ops register their result on the start edge (latency 1).
// MUL is an unsigned shift-add multiply that takes W steps and produces a
// 2W-bit product in {Y_hi, Y} (latency W+1).
module alu_seq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] selector,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  Y,
  output logic [W-1:0]  Y_hi,
  output logic          C,
  output logic          ZERO,
  output logic          OVF
);

  localparam int CNTW = $clog2(W);

  localparam logic [CW-1:0] OP_PASSA = CW'(0);
  localparam logic [CW-1:0] OP_SUB   = CW'(1);
  localparam logic [CW-1:0] OP_PASSB = CW'(2);
  localparam logic [CW-1:0] OP_ADD   = CW'(3);
  localparam logic [CW-1:0] OP_NAND  = CW'(4);
  localparam logic [CW-1:0] OP_XOR   = CW'(5);
  localparam logic [CW-1:0] OP_SHL   = CW'(6);
  localparam logic [CW-1:0] OP_MUL   = CW'(7);

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state;
  logic [W:0]        sum;
  logic [W:0]        diff;
  logic [W-1:0]      res;
  logic              res_c;
  logic              res_ovf;
  logic [2*W-1:0]    mcand;
  logic [W-1:0]      mplier;
  logic [2*W-1:0]    acc;
  logic [2*W-1:0]    acc_nxt;
  logic [CNTW-1:0]   cnt;

  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result and flags, computed straight from the live operands.
  always_comb begin
    // NOTE: every output gets a default first, so no case path can infer a latch.
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    res     = '0;
    res_c   = 1'b0;
    res_ovf = 1'b0;
    case (selector)
      OP_PASSA: res = A;
      OP_SUB: begin
        res     = diff[W-1:0];
        res_c   = diff[W];
        res_ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_PASSB: res = B;
      OP_ADD: begin
        res     = sum[W-1:0];
        res_c   = sum[W];
        res_ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_NAND:  res = ~(A & B);
      OP_XOR:   res = A ^ B;
      OP_SHL: begin
        res   = {A[W-2:0], 1'b0};
        res_c = A[W-1];
      end
      default: ;  // MUL goes through the FSM
    endcase
  end

  // Control FSM plus registered result/flags; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Y      <= '0;
      Y_hi   <= '0;
      C      <= 1'b0;
      ZERO   <= 1'b0;
      OVF    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (selector == OP_MUL) begin
              mcand  <= {{W{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              Y    <= res;
              Y_hi <= '0;
              C    <= res_c;
              ZERO <= (res == '0);
              OVF  <= res_ovf;
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(W - 1)) begin
            {Y_hi, Y} <= acc_nxt;
            C         <= (acc_nxt[2*W-1:W] != '0);
            ZERO      <= (acc_nxt == '0);
            OVF       <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
